// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file: one write port, two combinational read ports, clear sweep after reset
//
// Parameters:
//   DATA_W  entry width
//   ADDR_W  address width, DEPTH = 2**ADDR_W entries
//   BYPASS  1: a read port addressing the entry being written shows w_data in the same cycle
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   w_en      write enable (ignored until ready)
//   w_addr    write address
//   w_data    write data
//   r_addr_a  read port A address
//   r_data_a  read port A data (combinational)
//   r_addr_b  read port B address
//   r_data_b  read port B data (combinational)
//   ready     high once every entry has been cleared and writes are accepted
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr_a,
    output logic [DATA_W-1:0] r_data_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [DATA_W-1:0] r_data_b,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_live;
    logic              fwd_a;
    logic              fwd_b;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next-state logic: sweep one entry per edge, leave CLEAR after the last one
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end
    end

    // Output logic: the single storage write port is shared between the
    // clear sweep and the user port; the user port only owns it in RUN,
    // so writes during CLEAR are simply dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
        end else begin
            mem_we    = w_en;
            mem_waddr = w_addr;
            mem_wdata = w_data;
        end
    end

    assign ready = (state_q == ST_RUN);

    // Storage has no reset of its own; its contents are defined by the sweep.
    // rst_n gates the write so that reset always wins over write and sweep.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Reads are forced to zero whenever the contents are not yet defined,
    // including the cycles where rst_n is low before the state register sees it.
    assign rd_live = rst_n && (state_q == ST_RUN);
    assign fwd_a   = (BYPASS != 0) && w_en && (r_addr_a == w_addr);
    assign fwd_b   = (BYPASS != 0) && w_en && (r_addr_b == w_addr);

    always_comb begin
        r_data_a = '0;
        r_data_b = '0;
        if (rd_live) begin
            r_data_a = fwd_a ? w_data : mem_q[r_addr_a];
            r_data_b = fwd_b ? w_data : mem_q[r_addr_b];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp, with and without bypass
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic [2:0]  r_addr_a;
    logic [2:0]  r_addr_b;
    logic [15:0] ra0, rb0, ra1, rb1;
    logic        rdy0, rdy1;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: contents plus number of clear edges seen since reset
    logic [15:0] mem_m [DEPTH];
    int          clr_cnt = 0;

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_data_a(ra0), .r_addr_b(r_addr_b), .r_data_b(rb0),
        .ready(rdy0)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_data_a(ra1), .r_addr_b(r_addr_b), .r_data_b(rb1),
        .ready(rdy1)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea0;
        logic [15:0] eb0;
        logic [15:0] ea1;
        logic [15:0] eb1;
        logic        do_step;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [15:0] ea0, input logic [15:0] eb0,
                                input logic [15:0] ea1, input logic [15:0] eb1,
                                input logic do_step);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1; v.do_step = do_step;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected read value from the current inputs and model state
    function automatic logic [15:0] exp_rd(input logic byp, input logic [2:0] a);
        if (!rst_n || clr_cnt < DEPTH) return 16'h0;
        if (byp && w_en && a == w_addr) return w_data;
        return mem_m[a];
    endfunction

    // One rising edge; the model applies the same edge using the inputs held across it
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            clr_cnt = 0;
        end else if (clr_cnt < DEPTH) begin
            mem_m[clr_cnt] = 16'h0;
            clr_cnt++;
        end else if (w_en) begin
            mem_m[w_addr] = w_data;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        #1;
        chk({tag, " ra0"}, {16'h0, ra0}, {16'h0, exp_rd(1'b0, r_addr_a)});
        chk({tag, " rb0"}, {16'h0, rb0}, {16'h0, exp_rd(1'b0, r_addr_b)});
        chk({tag, " ra1"}, {16'h0, ra1}, {16'h0, exp_rd(1'b1, r_addr_a)});
        chk({tag, " rb1"}, {16'h0, rb1}, {16'h0, exp_rd(1'b1, r_addr_b)});
        chk({tag, " ready"}, {30'h0, rdy1, rdy0}, (clr_cnt >= DEPTH) ? 32'h3 : 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0; r_addr_a = '0; r_addr_b = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0;

        // Reset state
        step();
        step();
        #1;
        chk("reset ready", {30'h0, rdy1, rdy0}, 32'h0);
        chk("reset ra0", {16'h0, ra0}, 32'h0);
        chk("reset rb1", {16'h0, rb1}, 32'h0);

        // Clear sweep with a write attempted throughout
        rst_n = 1'b1; w_en = 1'b1; w_addr = 3'd5; w_data = 16'hBEEF;
        for (int k = 1; k <= DEPTH; k++) begin
            r_addr_a = 3'(k - 1);
            r_addr_b = 3'd5;
            #1;
            chk($sformatf("clear ready before edge %0d", k), {30'h0, rdy1, rdy0}, 32'h0);
            chk($sformatf("clear ra1 edge %0d", k), {16'h0, ra1}, 32'h0);
            chk($sformatf("clear rb1 edge %0d", k), {16'h0, rb1}, 32'h0);
            step();
        end
        w_en = 1'b0;
        #1;
        chk("ready after 8 edges", {30'h0, rdy1, rdy0}, 32'h3);
        for (int a = 0; a < DEPTH; a++) begin
            r_addr_a = 3'(a);
            r_addr_b = 3'(7 - a);
            #1;
            chk($sformatf("cleared a%0d", a), {ra1, ra0}, 32'h0);
            chk($sformatf("cleared b%0d", 7 - a), {rb1, rb0}, 32'h0);
        end

        // Fill every entry
        for (int i = 0; i < DEPTH; i++) begin
            w_en = 1'b1; w_addr = 3'(i); w_data = 16'h100 + 16'(i);
            step();
        end
        w_en = 1'b0;

        // Table-driven reads and same-address write/read
        for (int i = 0; i < DEPTH; i++) begin
            tbl.push_back(mk(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i),
                             16'h100 + 16'(i), 16'h107 - 16'(i),
                             16'h100 + 16'(i), 16'h107 - 16'(i), 1'b0));
        end
        tbl.push_back(mk(1'b1, 3'd3, 16'h0009, 3'd3, 3'd4, 16'h0103, 16'h0104, 16'h0009, 16'h0104, 1'b1));
        tbl.push_back(mk(1'b1, 3'd3, 16'h0042, 3'd3, 3'd4, 16'h0009, 16'h0104, 16'h0042, 16'h0104, 1'b1));
        tbl.push_back(mk(1'b0, 3'd3, 16'h0000, 3'd3, 3'd4, 16'h0042, 16'h0104, 16'h0042, 16'h0104, 1'b1));
        tbl.push_back(mk(1'b0, 3'd3, 16'h0000, 3'd3, 3'd4, 16'h0042, 16'h0104, 16'h0042, 16'h0104, 1'b0));

        foreach (tbl[n]) begin
            w_en = tbl[n].we; w_addr = tbl[n].wa; w_data = tbl[n].wd;
            r_addr_a = tbl[n].ra; r_addr_b = tbl[n].rb;
            #1;
            chk($sformatf("vec%0d ra0", n), {16'h0, ra0}, {16'h0, tbl[n].ea0});
            chk($sformatf("vec%0d rb0", n), {16'h0, rb0}, {16'h0, tbl[n].eb0});
            chk($sformatf("vec%0d ra1", n), {16'h0, ra1}, {16'h0, tbl[n].ea1});
            chk($sformatf("vec%0d rb1", n), {16'h0, rb1}, {16'h0, tbl[n].eb1});
            if (tbl[n].do_step) step();
        end
        w_en = 1'b0;

        // Randomised traffic against the model, with occasional resets
        for (int n = 0; n < 300; n++) begin
            rst_n    = ($urandom_range(0, 39) != 0);
            w_en     = 1'($urandom_range(0, 1));
            w_addr   = 3'($urandom_range(0, 7));
            w_data   = 16'($urandom);
            r_addr_a = ($urandom_range(0, 3) == 0) ? w_addr : 3'($urandom_range(0, 7));
            r_addr_b = 3'($urandom_range(0, 7));
            chk_model($sformatf("rand%0d", n));
            step();
        end
        rst_n = 1'b1; w_en = 1'b0;
        for (int k = 0; k < DEPTH; k++) step();

        // Non-zero contents, then reset concurrent with a write
        for (int i = 0; i < DEPTH; i++) begin
            w_en = 1'b1; w_addr = 3'(i); w_data = 16'hA000 + 16'(i);
            step();
        end
        w_en = 1'b0; r_addr_a = 3'd2; r_addr_b = 3'd6;
        #1;
        chk("prefill a2", {16'h0, ra0}, 32'hA002);
        chk("prefill b6", {16'h0, rb1}, 32'hA006);
        rst_n = 1'b0; w_en = 1'b1; w_addr = 3'd2; w_data = 16'h5555;
        #1;
        chk("rst low reads forced", {ra1, ra0}, 32'h0);
        step();
        chk("rst ready drop", {30'h0, rdy1, rdy0}, 32'h0);
        chk("rst reads zero", {rb1, rb0}, 32'h0);
        rst_n = 1'b1; w_en = 1'b0;
        for (int k = 0; k < DEPTH; k++) step();
        chk("rst ready back", {30'h0, rdy1, rdy0}, 32'h3);
        for (int a = 0; a < DEPTH; a++) begin
            r_addr_a = 3'(a);
            r_addr_b = 3'(7 - a);
            #1;
            chk($sformatf("recleared a%0d", a), {ra1, ra0}, 32'h0);
            chk($sformatf("recleared b%0d", 7 - a), {rb1, rb0}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
